// File: rtl/opendap_swd_link_ctrl.sv
// SWD link-layer state controller: dormant/lockout/reset/active/deselected sequencing,
// response gating, abort and error counting. Multidrop via OPENDAP_SWD_MULTIDROP_EN.
//
// state      | meaning
// DORMANT    | link asleep, engine disabled, only exit_dormant honoured
// LOCKOUT    | awake but not synchronised; waits for line reset
// RESET      | line reset seen; only a DPIDR read may be answered
// ACTIVE     | link up, all packets answered
// DESELECTED | multidrop target not selected; never answers
module opendap_swd_link_ctrl #(
  parameter int W_ERRCNT = 4
) (
  input  logic                swclk,
  input  logic                rst_n,
  input  logic                exit_dormant,
  input  logic                enter_dormant,
  input  logic                line_reset,
  input  logic                pkt_hdr_valid,
  input  logic                pkt_hdr_dpidr_rd,
  input  logic                pkt_done,
  input  logic                pkt_err,
  input  logic                targetsel_wr,
  input  logic                targetsel_match,
  input  logic                clr_err,
  output logic [2:0]          link_state,
  output logic                engine_en,
  output logic                resp_en,
  output logic                engine_abort,
  output logic [W_ERRCNT-1:0] err_cnt
);

  typedef enum logic [2:0] {
    ST_DORMANT    = 3'd0,
    ST_LOCKOUT    = 3'd1,
    ST_RESET      = 3'd2,
    ST_ACTIVE     = 3'd3,
    ST_DESELECTED = 3'd4
  } state_t;

  localparam logic [W_ERRCNT-1:0] ERR_MAX = '1;

  state_t state, state_nxt;
  logic   busy, hdr_dpidr;
  logic   live, pkt_ok, deselect, resp_grant;
  logic   ev_enter, ev_lr, ev_exit, ev_err, ev_done, ev_hdr, pkt_end;

  // Only one event is acted on per cycle; lower-priority inputs are masked.
  assign live     = (state != ST_DORMANT) && (state <= ST_DESELECTED);
  assign ev_enter = live & enter_dormant;
  assign ev_lr    = live & line_reset & ~enter_dormant;
  assign ev_exit  = (state == ST_DORMANT) & exit_dormant & ~enter_dormant;
  assign pkt_ok   = live & ~enter_dormant & ~line_reset;
  assign ev_err   = pkt_ok & pkt_err;
  assign ev_done  = pkt_ok & ~pkt_err & pkt_done & busy;
  assign ev_hdr   = pkt_ok & ~pkt_err & ~(pkt_done & busy) & pkt_hdr_valid;
  assign pkt_end  = ev_enter | ev_lr | ev_err | ev_done;

  assign resp_grant = (state == ST_ACTIVE) | ((state == ST_RESET) & pkt_hdr_dpidr_rd);

`ifdef OPENDAP_SWD_MULTIDROP_EN
  assign deselect = targetsel_wr & ~targetsel_match;
`else
  logic unused_tsel;
  assign unused_tsel = targetsel_wr ^ targetsel_match;
  assign deselect    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (!live && state != ST_DORMANT) begin
      state_nxt = ST_DORMANT;
    end else if (ev_enter) begin
      state_nxt = ST_DORMANT;
    end else if (ev_lr) begin
      state_nxt = ST_RESET;
    end else if (ev_exit) begin
      state_nxt = ST_LOCKOUT;
    end else if (ev_err && (state == ST_RESET || state == ST_ACTIVE)) begin
      state_nxt = ST_LOCKOUT;
    end else if (ev_done && state == ST_RESET) begin
      if (hdr_dpidr)     state_nxt = ST_ACTIVE;
      else if (deselect) state_nxt = ST_DESELECTED;
    end
  end

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_DORMANT;
      engine_en    <= 1'b0;
      engine_abort <= 1'b0;
      resp_en      <= 1'b0;
      busy         <= 1'b0;
      hdr_dpidr    <= 1'b0;
      err_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      engine_en    <= (state_nxt != ST_DORMANT);
      engine_abort <= (ev_enter | ev_lr) & busy;

      if (!live || pkt_end) begin
        busy    <= 1'b0;
        resp_en <= 1'b0;
      end else if (ev_hdr) begin
        busy      <= 1'b1;
        resp_en   <= resp_grant;
        hdr_dpidr <= pkt_hdr_dpidr_rd;
      end

      if (clr_err)
        err_cnt <= '0;
      else if (ev_err && state != ST_DESELECTED && err_cnt != ERR_MAX)
        err_cnt <= err_cnt + 1'b1;
    end
  end

  assign link_state = state;

endmodule

// File: doc/opendap_swd_link_ctrl.md
OPENDAP_SWD_LINK_CTRL -- requirements
Module: opendap_swd_link_ctrl

Interface
REQ-001 Parameter: W_ERRCNT, 4, width of saturating protocol-error counter.
REQ-002 swclk  input  1  sole clock; all logic on posedge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 exit_dormant, enter_dormant, line_reset  input  1 each  single-cycle pulses from dormant monitor.
REQ-005 pkt_hdr_valid  input  1  pulse: SWD engine has parsed a parity-correct header.
REQ-006 pkt_hdr_dpidr_rd  input  1  qualifies pkt_hdr_valid: header is DP read of addr 0x0 (DPIDR).
REQ-007 pkt_done  input  1  pulse: packet completed without error.
REQ-008 pkt_err  input  1  pulse: header parity, data parity or protocol error.
REQ-009 targetsel_wr, targetsel_match  input  1 each  qualify pkt_done: packet was TARGETSEL write; ID matched.
REQ-010 clr_err  input  1  pulse: clear err_cnt.
REQ-011 link_state  output  3  current state encoding (REQ-014).
REQ-012 engine_en, resp_en, engine_abort  output  1 each  engine enable; target may drive ACK/data; abort pulse.
REQ-013 err_cnt  output  W_ERRCNT  saturating count of pkt_err events.

Function
REQ-014 States SHALL be DORMANT=0, LOCKOUT=1, RESET=2, ACTIVE=3, DESELECTED=4; other codes go to DORMANT next cycle.
REQ-015 Priority per cycle, highest first: enter_dormant, line_reset, exit_dormant, pkt_err, pkt_done, pkt_hdr_valid.
REQ-016 Any non-DORMANT state + enter_dormant -> DORMANT.
REQ-017 Any non-DORMANT state + line_reset -> RESET; DORMANT ignores line_reset, pkt_* inputs.
REQ-018 DORMANT + exit_dormant -> LOCKOUT; exit_dormant ignored in other states.
REQ-019 RESET + pkt_done with pkt_hdr_dpidr_rd latched at header time -> ACTIVE; other pkt_done stays RESET.
REQ-020 ACTIVE or RESET + pkt_err -> LOCKOUT; LOCKOUT exits only via line_reset/enter_dormant.
REQ-021 engine_en SHALL be 1 in all states except DORMANT, registered from state.
REQ-022 resp_en SHALL set the cycle after pkt_hdr_valid iff state ACTIVE, or state RESET with pkt_hdr_dpidr_rd=1; clear the cycle after pkt_done, pkt_err, line_reset or enter_dormant.
REQ-023 Internal busy flag SHALL set on pkt_hdr_valid, clear on pkt_done/pkt_err.
REQ-024 engine_abort SHALL pulse one cycle after line_reset or enter_dormant when busy=1; busy clears same edge.
REQ-025 err_cnt SHALL increment on pkt_err in any non-DORMANT state, saturate at all-ones, never wrap; clr_err coincident with pkt_err yields 0.
REQ-026 pkt_done and pkt_err in same cycle SHALL be treated as pkt_err only.
REQ-027 pkt_done with busy=0 SHALL be ignored (no state change).

Reset
REQ-028 Under rst_n low: link_state=DORMANT, engine_en=0, resp_en=0, engine_abort=0, err_cnt=0, busy=0.
REQ-029 Reset deassertion mid-packet SHALL require exit_dormant then line_reset before any resp_en.

Configuration
REQ-030 Macro OPENDAP_SWD_MULTIDROP_EN: when defined, RESET + pkt_done with targetsel_wr=1, targetsel_match=0 -> DESELECTED; match=1 stays RESET.
REQ-031 DESELECTED: resp_en held 0, pkt_err does not count, exit only via line_reset/enter_dormant.
REQ-032 Without macro: targetsel_* ignored, DESELECTED unreachable, ports still present.

Verification
REQ-033 Reset; exit_dormant; line_reset -> link_state 0->1->2, engine_en=1 from state 1.
REQ-034 In RESET, hdr_valid with dpidr_rd=0 -> resp_en stays 0; then DPIDR read + pkt_done -> resp_en=1 during packet, state ACTIVE.
REQ-035 ACTIVE, 20 pkt_err pulses (W_ERRCNT=4) -> LOCKOUT, err_cnt=15; clr_err -> 0.
REQ-036 ACTIVE, busy, line_reset and enter_dormant same cycle -> DORMANT, engine_abort one cycle, resp_en=0.
REQ-037 With macro: RESET, TARGETSEL match=0 pkt_done -> state 4, DPIDR hdr gives resp_en=0; line_reset -> state 2. Without macro: state stays 2.
REQ-038 pkt_done and pkt_err same cycle in RESET -> LOCKOUT, err_cnt+1.
